// File: rtl/mem_map_pkg.sv
// Address map constants and STATUS layout shared by the data-side responder.
package mem_map_pkg;
    localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_FF00;

    localparam logic [31:0] OFS_OUT_DATA = 32'd0;
    localparam logic [31:0] OFS_STATUS   = 32'd4;
    localparam logic [31:0] OFS_CYCLE    = 32'd8;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 3;
    localparam int ST_CNT_W   = 5;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_OUT,
        SEL_STATUS,
        SEL_CYCLE
    } sel_t;

    function automatic logic [31:0] status_word(input logic full, input logic empty,
                                                input logic ovf, input logic [ST_CNT_W-1:0] cnt);
        logic [31:0] s;
        s = '0;
        s[ST_FULL]  = full;
        s[ST_EMPTY] = empty;
        s[ST_OVF]   = ovf;
        s[ST_CNT_LSB +: ST_CNT_W] = cnt;
        return s;
    endfunction
endpackage

// File: rtl/dmem_mmio_out_fifo.sv
// Output FIFO for the MMIO region: registered head, no bypass, head reads 0 when empty.
module out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             pop_ok, push_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A pop frees a slot in the same edge, so a full FIFO still accepts a push alongside it.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end
endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO (output FIFO, STATUS, optional CYCLE) answering the core combinationally.
// Define DMEM_CYCLE_COUNTER_EN to include the free-running CYCLE counter.
module dmem_mmio
    import mem_map_pkg::*;
#(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready
);
    localparam int RA = $clog2(RAM_WORDS);
    localparam int FA = $clog2(FIFO_DEPTH);
    localparam logic [31:0] A_OUT    = MMIO_BASE + OFS_OUT_DATA;
    localparam logic [31:0] A_STATUS = MMIO_BASE + OFS_STATUS;
    localparam logic [31:0] A_CYCLE  = MMIO_BASE + OFS_CYCLE;

    sel_t        sel;
    logic [31:0] ram [RAM_WORDS];
    logic        f_full, f_empty, f_pop, overflow;
    logic [FA:0] f_count;
    logic [31:0] cycle_q;
    logic        unused_lsb;

    assign unused_lsb = ^aluout[1:0];

    always_comb begin
        sel = SEL_NONE;
        if (aluout[31:RA+2] == '0)                sel = SEL_RAM;
        else if (aluout[31:2] == A_OUT[31:2])     sel = SEL_OUT;
        else if (aluout[31:2] == A_STATUS[31:2])  sel = SEL_STATUS;
`ifdef DMEM_CYCLE_COUNTER_EN
        else if (aluout[31:2] == A_CYCLE[31:2])   sel = SEL_CYCLE;
`endif
    end

    always_ff @(posedge clk) begin
        if (memwrite && sel == SEL_RAM) ram[aluout[RA+1:2]] <= writedata;
    end

    assign out_valid = !f_empty;
    assign f_pop     = out_valid && out_ready;

    out_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (memwrite && sel == SEL_OUT),
        .din   (writedata),
        .pop   (f_pop),
        .dout  (out_data),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    always_ff @(posedge clk) begin
        if (reset)                              overflow <= 1'b0;
        else if (memwrite && sel == SEL_STATUS) overflow <= 1'b0;
        else if (memwrite && sel == SEL_OUT && f_full && !f_pop) overflow <= 1'b1;
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    always_ff @(posedge clk) begin
        if (reset) cycle_q <= '0;
        else       cycle_q <= cycle_q + 32'd1;
    end
`else
    assign cycle_q = '0;
`endif

    always_comb begin
        readdata = '0;
        case (sel)
            SEL_RAM:    readdata = ram[aluout[RA+1:2]];
            SEL_OUT:    readdata = out_data;
            SEL_STATUS: readdata = status_word(f_full, f_empty, overflow, ST_CNT_W'(f_count));
            SEL_CYCLE:  readdata = cycle_q;
            default:    readdata = '0;
        endcase
    end
endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side responder for the single-cycle MIPS core: it answers the core's `memwrite` / `aluout` / `writedata` request with `readdata` in the same cycle. It holds a word-addressed data RAM and a small memory-mapped I/O region. The I/O region contains an output FIFO that drains to an external consumer over a valid/ready handshake, and a free-running cycle counter. It sits beside the core at the top level, in place of a plain data memory.

## Interface
Parameters:
- `RAM_WORDS`, 64: number of 32-bit RAM words; power of two.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, at least 2.
- `MMIO_BASE`, 32'hFFFF_FF00: base address of the I/O region.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `memwrite` input 1: write strobe from the core.
- `aluout` input 32: byte address from the core.
- `writedata` input 32: store data.
- `readdata` output 32: load data; combinational from `aluout` and current state.
- `out_valid` output 1: FIFO head is valid.
- `out_data` output 32: FIFO head word.
- `out_ready` input 1: consumer accepts the head this cycle.

## Operation
Address decode:
- `aluout[1:0]` is ignored; all accesses are word accesses.
- RAM: addresses 0 to RAM_WORDS*4-1, indexed by `aluout[log2(RAM_WORDS)+1:2]`.
- OUT_DATA at MMIO_BASE+0:
  - Write pushes `writedata`.
  - Read returns the head word, or 0 when empty. A read does not pop.
- STATUS at MMIO_BASE+4, read value:
  - bit0 full
  - bit1 empty
  - bit2 overflow (sticky)
  - bits[7:3] occupancy count
  - all other bits 0
  - Any write clears overflow.
- CYCLE at MMIO_BASE+8: read returns the counter; writes are ignored.
- Any other address: reads return 0; writes are ignored.

RAM:
- Write on the rising edge when `memwrite` is high.
- Read is asynchronous.
- Contents are not reset; the initial value is undefined.

FIFO:
- Push when `memwrite` targets OUT_DATA and the push is accepted.
- A push is accepted when the FIFO is not full, or when a pop occurs in the same cycle.
- A rejected push leaves the FIFO unchanged and sets overflow.
- Pop when `out_valid && out_ready`.
- Push and pop in the same cycle: occupancy is unchanged and the head advances.
- Push into an empty FIFO: that word appears at `out_valid`/`out_data` on the next cycle. There is no bypass.
- Read/write pointers wrap modulo FIFO_DEPTH; the count saturates to neither 0 nor DEPTH incorrectly.
- `out_data` is 0 when empty.

Cycle counter:
- 32-bit, increments every cycle after reset, wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values:
  - `out_valid` = 0
  - `out_data` = 0
  - FIFO empty, count 0
  - overflow = 0
  - counter = 0
  - `readdata` reflects the reset state for MMIO addresses
- Reset mid-operation discards all FIFO contents in the same edge; RAM is untouched.
- Read latency is 0 cycles (combinational), as required by the single-cycle core.
- Store to RAM or FIFO is visible to a load at the same address on the following cycle.
- CYCLE read on cycle N after reset returns N-1. The first cycle after reset deasserts reads 0.
- `out_valid` must not depend combinationally on `out_ready`. The consumer may hold `out_ready` high indefinitely.

## Configuration
- Macro `DMEM_CYCLE_COUNTER_EN`.
- Defined: the CYCLE register and counter are present as described.
- Undefined: the counter logic is removed entirely, and CYCLE reads 0 like an unmapped address.
- The address map is otherwise identical in both cases.

## Structure
- Package `mem_map_pkg` holds:
  - register offsets: `OFS_OUT_DATA` = 0, `OFS_STATUS` = 4, `OFS_CYCLE` = 8
  - STATUS bit indices
  - default MMIO_BASE
- One sub-module, `out_fifo`:
  - parameterized by depth and width
  - push/pop/full/empty/count ports
  - owns the pointers and storage
- The top handles decode, RAM, overflow, counter and the read mux.

## Test plan
- Reset, then store 32'hDEADBEEF to address 0x10, then load 0x10 on the next cycle -> `readdata` = 32'hDEADBEEF; load 0x200 (unmapped) -> 0.
- With `out_ready` = 0, write 1, 2, 3, 4 to OUT_DATA -> STATUS = full, count 4, `out_valid` = 1, `out_data` = 1. A fifth write of 5 -> STATUS overflow = 1, contents unchanged.
- From full, hold `out_ready` = 1 and write 9 in the same cycle -> head pops 1 and 9 is accepted, count stays 4. Drain all -> order 2, 3, 4, 9, then `out_valid` = 0, `out_data` = 0.
- Write STATUS -> overflow clears. Assert reset with 3 entries queued -> next cycle empty, `out_valid` = 0, and RAM word at 0x10 is still 32'hDEADBEEF.
- With `DMEM_CYCLE_COUNTER_EN`: read CYCLE 10 cycles after reset deasserts -> 9. Force the counter to 32'hFFFF_FFFF -> the next cycle reads 0. Without the macro: CYCLE reads 0.
